// File: rtl/lsu_mmio_stage.sv
// MEM-stage load/store unit: byte-lane DMEM, UART TX FIFO and 64-bit timer behind MMIO decode.
// Optional build macro: MISALIGN_TRAP_EN suppresses and flags misaligned half/word accesses.
module lsu_mmio_stage #(
  parameter logic [31:0] DMEM_BASE     = 32'h1000_0000,
  parameter int          DMEM_AW       = 18,
  parameter logic [31:0] UART_ADDR     = 32'hFFFF_FFFC,
  parameter logic [31:0] TIMER_LO_ADDR = 32'hFFFF_FF00,
  parameter logic [31:0] TIMER_HI_ADDR = 32'hFFFF_FF04,
  parameter int          TX_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] read_data,
  output logic [31:0] calc_result,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int IW = DMEM_AW - 2;

  typedef enum logic [1:0] {SRC_ZERO, SRC_DMEM, SRC_TLO, SRC_THI} src_e;

  logic [31:0] dmem_q [0:(1<<IW)-1];
  logic [7:0]  fifo_q [0:TX_DEPTH-1];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q, count_d;
  logic [63:0]   timer_q;
  logic [31:0]   snap_q, ldval_q, rword_q;
  logic          rsp_valid_q, misalign_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  src_e          src_q, src_d;

  logic [31:0] dmem_off, wlane;
  logic [IW-1:0] widx;
  logic [3:0]  wstrb;
  logic [1:0]  byte_off;
  logic        in_dmem, is_uart, is_tlo, is_thi;
  logic        accept, misaligned, fifo_full, do_store, push, pop;

  assign calc_result = addr;
  assign dmem_off    = addr - DMEM_BASE;
  assign in_dmem     = (dmem_off >> DMEM_AW) == 32'd0;
  assign widx        = dmem_off[DMEM_AW-1:2];
  assign byte_off    = addr[1:0];
  assign is_uart     = !in_dmem && addr == UART_ADDR;
  assign is_tlo      = !in_dmem && addr == TIMER_LO_ADDR;
  assign is_thi      = !in_dmem && addr == TIMER_HI_ADDR;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0]) ||
                      (funct3 == 3'b010 && addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A full FIFO stalls the push even when a pop frees a slot in the same cycle.
  assign fifo_full = count_q == (PW+1)'(TX_DEPTH);
  assign stall     = req_valid && mem_write && addr == UART_ADDR && fifo_full;
  assign accept    = req_valid && !stall;
  assign do_store  = accept && mem_write && !misaligned;
  assign push      = do_store && is_uart;
  assign pop       = count_q != '0 && tx_ready;

  assign tx_valid  = count_q != '0;
  assign tx_data   = tx_valid ? fifo_q[rptr_q] : 8'h00;

  always_comb begin
    wstrb = '0;
    wlane = '0;
    if (do_store && in_dmem) begin
      case (funct3)
        3'b000: begin wstrb = 4'b0001 << byte_off; wlane = {4{wdata[7:0]}}; end
        3'b001: begin wstrb = byte_off[1] ? 4'b1100 : 4'b0011; wlane = {2{wdata[15:0]}}; end
        3'b010: begin wstrb = 4'b1111; wlane = wdata; end
        default: ;
      endcase
    end
  end

  always_comb begin
    src_d = SRC_ZERO;
    if (!misaligned) begin
      if (in_dmem)     src_d = SRC_DMEM;
      else if (is_tlo) src_d = SRC_TLO;
      else if (is_thi) src_d = SRC_THI;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  // Storage arrays carry no reset; the load word is read synchronously at accept.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++)
      if (wstrb[b]) dmem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
    if (accept && mem_read && in_dmem) rword_q <= dmem_q[widx];
    if (push) fifo_q[wptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q     <= '0;
      snap_q      <= '0;
      ldval_q     <= '0;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      src_q       <= SRC_ZERO;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      timer_q     <= timer_q + 64'd1;
      rsp_valid_q <= accept && mem_read;
      misalign_q  <= accept && (mem_read || mem_write) && misaligned;
      if (accept && mem_read) begin
        funct3_q <= funct3;
        off_q    <= byte_off;
        src_q    <= src_d;
        ldval_q  <= (src_d == SRC_THI) ? snap_q : timer_q[31:0];
        if (src_d == SRC_TLO) snap_q <= timer_q[63:32];
      end
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] ext;
  assign lbyte = 8'(rword_q >> {off_q, 3'b000});
  assign lhalf = off_q[1] ? rword_q[31:16] : rword_q[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  ext = {{24{lbyte[7]}}, lbyte};
      3'b100:  ext = {24'h0, lbyte};
      3'b001:  ext = {{16{lhalf[15]}}, lhalf};
      3'b101:  ext = {16'h0, lhalf};
      default: ext = rword_q;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (rsp_valid_q) begin
      case (src_q)
        SRC_DMEM:         read_data = ext;
        SRC_TLO, SRC_THI: read_data = ldval_q;
        default:          read_data = '0;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_lsu_mmio_stage.sv
// Directed self-checking bench for lsu_mmio_stage (honours MISALIGN_TRAP_EN when defined).
module tb_lsu_mmio_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, rsp_valid, tx_valid, tx_ready = 1'b0, misalign_err;
  logic [31:0] read_data, calc_result;
  logic [7:0]  tx_data;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [63:0] cyc;

  localparam logic [31:0] UART = 32'hFFFF_FFFC;
  localparam logic [31:0] TLO  = 32'hFFFF_FF00;
  localparam logic [31:0] THI  = 32'hFFFF_FF04;

  lsu_mmio_stage dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rsp_valid(rsp_valid),
    .read_data(read_data), .calc_result(calc_result), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Reference cycle count: cleared by reset, +1 per clock afterwards.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= '0;
    else     cyc <= cyc + 64'd1;

  task automatic idle();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = f3; addr = a; wdata = d;
    @(posedge clk); #1 idle();
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a,
                      output logic [31:0] d, output logic v, output logic m);
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
    @(posedge clk); #1 idle();
    @(negedge clk);
    d = read_data; v = rsp_valid; m = misalign_err;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({stall, rsp_valid, read_data, tx_valid, tx_data, misalign_err} !== 43'd0) begin
      $display("FAIL reset_outputs got=%h want=0", {stall, rsp_valid, read_data, tx_valid, tx_data, misalign_err});
    end else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    addr = 32'h1234_5678; #1;
    total_cnt++;
    if (calc_result !== 32'h1234_5678) $display("FAIL calc_result got=%h want=12345678", calc_result);
    else pass_cnt++;
  endtask

  task automatic test_byte_loads();
    logic [31:0] d; logic v, m;
    store(3'b010, 32'h1000_0000, 32'hA1B2_C3D4);
    load(3'b000, 32'h1000_0003, d, v, m);
    total_cnt++;
    if (d !== 32'hFFFF_FFA1 || v !== 1'b1) $display("FAIL lb got=%h/%b want=ffffffa1/1", d, v);
    else pass_cnt++;
    load(3'b100, 32'h1000_0003, d, v, m);
    total_cnt++;
    if (d !== 32'h0000_00A1) $display("FAIL lbu got=%h want=000000a1", d);
    else pass_cnt++;
    load(3'b000, 32'h1000_0000, d, v, m);
    total_cnt++;
    if (d !== 32'hFFFF_FFD4) $display("FAIL lb0 got=%h want=ffffffd4", d);
    else pass_cnt++;
    load(3'b011, 32'h1000_0000, d, v, m);
    total_cnt++;
    if (d !== 32'hA1B2_C3D4) $display("FAIL raw_f3 got=%h want=a1b2c3d4", d);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL rsp_one_cycle got=%b want=0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_half();
    logic [31:0] d; logic v, m;
    store(3'b010, 32'h1000_0004, 32'h1122_3344);
    store(3'b001, 32'h1000_0006, 32'hFFFF_8001);
    load(3'b010, 32'h1000_0004, d, v, m);
    total_cnt++;
    if (d !== 32'h8001_3344) $display("FAIL lw_after_sh got=%h want=80013344", d);
    else pass_cnt++;
    load(3'b001, 32'h1000_0006, d, v, m);
    total_cnt++;
    if (d !== 32'hFFFF_8001) $display("FAIL lh got=%h want=ffff8001", d);
    else pass_cnt++;
    load(3'b101, 32'h1000_0006, d, v, m);
    total_cnt++;
    if (d !== 32'h0000_8001) $display("FAIL lhu got=%h want=00008001", d);
    else pass_cnt++;
    store(3'b000, 32'h1000_0005, 32'h0000_00EE);
    load(3'b010, 32'h1000_0004, d, v, m);
    total_cnt++;
    if (d !== 32'h8001_EE44) $display("FAIL sb_lane got=%h want=8001ee44", d);
    else pass_cnt++;
  endtask

  task automatic test_uart();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b000; addr = UART; wdata = 32'hABCD_EF10 + i;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL uart_push%0d_stall got=%b want=0", i, stall);
      else pass_cnt++;
      @(posedge clk); #1 idle();
      if (i == 0) begin
        @(negedge clk);
        total_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h10) $display("FAIL uart_first got=%b/%h want=1/10", tx_valid, tx_data);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b000; addr = UART; wdata = 32'h0000_0018;
    tx_ready = 1'b1; #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL uart_full_stall got=%b want=1", stall);
    else pass_cnt++;
    @(negedge clk);
    tx_ready = 1'b0; #1;
    total_cnt++;
    if (stall !== 1'b0 || tx_data !== 8'h11) $display("FAIL uart_after_pop got=%b/%h want=0/11", stall, tx_data);
    else pass_cnt++;
    @(posedge clk); #1 idle();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) $display("FAIL uart_drain%0d got=%b/%h want=1/%h", i, tx_valid, tx_data, 8'(8'h10 + i));
      else pass_cnt++;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL uart_empty got=%b want=0", tx_valid);
    else pass_cnt++;
  endtask

  task automatic test_timer();
    logic [31:0] d; logic v, m; logic [63:0] e;
    @(negedge clk);
    e = cyc;
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = TLO;
    @(posedge clk); #1 idle();
    @(negedge clk);
    total_cnt++;
    if (read_data !== e[31:0] || rsp_valid !== 1'b1) $display("FAIL timer_lo got=%h want=%h", read_data, e[31:0]);
    else pass_cnt++;
    @(negedge clk);
    force dut.timer_q = 64'h0000_0001_FFFF_FFFF;
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = TLO;
    @(posedge clk); #1 idle();
    @(negedge clk);
    release dut.timer_q;
    total_cnt++;
    if (read_data !== 32'hFFFF_FFFF) $display("FAIL timer_lo_forced got=%h want=ffffffff", read_data);
    else pass_cnt++;
    load(3'b010, THI, d, v, m);
    total_cnt++;
    if (d !== 32'h0000_0001) $display("FAIL timer_hi_snapshot got=%h want=00000001", d);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic v, m;
    load(3'b010, 32'h2000_0000, d, v, m);
    total_cnt++;
    if (d !== 32'h0 || v !== 1'b1) $display("FAIL unmapped got=%h/%b want=0/1", d, v);
    else pass_cnt++;
    load(3'b010, UART, d, v, m);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL uart_load got=%h want=0", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    store(3'b000, UART, 32'h0000_0055);
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = TLO;
    @(posedge clk); #1 idle(); rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (rsp_valid !== 1'b0 || tx_valid !== 1'b0 || read_data !== 32'h0)
      $display("FAIL reset_mid got=%b/%b/%h want=0/0/0", rsp_valid, tx_valid, read_data);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic v, m;
    store(3'b010, 32'h1000_0000, 32'hA1B2_C3D4);
    load(3'b001, 32'h1000_0001, d, v, m);
`ifdef MISALIGN_TRAP_EN
    total_cnt++;
    if (d !== 32'h0 || m !== 1'b1 || v !== 1'b1) $display("FAIL misalign_lh got=%h/%b want=0/1", d, m);
    else pass_cnt++;
`else
    total_cnt++;
    if (d !== 32'hFFFF_C3D4 || m !== 1'b0) $display("FAIL unaligned_lh got=%h/%b want=ffffc3d4/0", d, m);
    else pass_cnt++;
`endif
    store(3'b010, 32'h1000_0002, 32'hDEAD_BEEF);
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    total_cnt++;
    if (misalign_err !== 1'b1) $display("FAIL misalign_sw_flag got=%b want=1", misalign_err);
    else pass_cnt++;
    load(3'b010, 32'h1000_0000, d, v, m);
    total_cnt++;
    if (d !== 32'hA1B2_C3D4) $display("FAIL misalign_sw_mem got=%h want=a1b2c3d4", d);
    else pass_cnt++;
`else
    total_cnt++;
    if (misalign_err !== 1'b0) $display("FAIL misalign_tied got=%b want=0", misalign_err);
    else pass_cnt++;
    load(3'b010, 32'h1000_0000, d, v, m);
    total_cnt++;
    if (d !== 32'hDEAD_BEEF) $display("FAIL unaligned_sw_mem got=%h want=deadbeef", d);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half();
    test_uart();
    test_timer();
    test_unmapped();
    test_reset_mid();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
